uart_rx_buf: RTL and testbench

UART_RX_BUF -- requirements
Module: uart_rx_buf

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_rx_buf.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_buf.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and rx FSM state encoding for the UART receive buffer.
// Optional build macro: UART_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

    localparam int CLK_DIV_DEF    = 13;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam int DEPTH_DEF      = 512;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP
    } rx_state_e;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted only when a
// valid pop happens in the same cycle, otherwise it is dropped and flagged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = cnt_q[AW];       // count never exceeds DEPTH
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & full_o & ~do_pop;

    // occupancy follows accepted pushes minus accepted pops
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // pointers and count; power-of-two depth makes wrap implicit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // storage is not reset; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver (8N1-style, oversampled) feeding a show-ahead FIFO, with
// sticky overflow / framing / parity flags.
// Optional build macro: UART_PARITY_EN enables an even parity bit.
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd_en,
    input  logic                   err_clr,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   frame_err,
    output logic                   parity_err
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    logic                 sync1_q, sync2_q, rxd_q, rx_s, fall;
    logic [DW-1:0]        div_q, div_d;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [OW-1:0]        os_q, os_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 os_mid, os_end, last_bit;
    logic                 os_clr, os_inc, bit_clr, shift_en, stop_chk;
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d, ovf_q, ovf_d;
    logic                 fifo_drop, push_ok;

    assign rx_s     = sync2_q;
    assign fall     = rxd_q & ~sync2_q;
    assign tick     = (div_q == DW'(CLK_DIV - 1));
    assign os_mid   = (os_q == OW'(OVERSAMPLE / 2 - 1));
    assign os_end   = (os_q == OW'(OVERSAMPLE - 1));
    assign last_bit = (bit_q == BW'(DATA_BITS - 1));

    // two-flop synchronizer plus one delayed copy for edge detection;
    // reset to idle level so reset itself never looks like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            rxd_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            rxd_q   <= sync2_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: only leaving IDLE is not tick-qualified
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START:  if (tick && os_mid) state_d = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_PARITY_EN
            ST_DATA:   if (tick && os_end && last_bit) state_d = ST_PARITY;
            ST_PARITY: if (tick && os_end) state_d = ST_STOP;
`else
            ST_DATA:   if (tick && os_end && last_bit) state_d = ST_STOP;
`endif
            ST_STOP:   if (tick && os_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic par_chk, par_bad_q, par_bad_d, perr_q, perr_d, par_miss;
    assign par_miss = par_chk & (rx_s != ^shift_q);
`endif

    // FSM outputs: counter control and sample strobes
    always_comb begin
        os_clr   = 1'b0;
        os_inc   = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        stop_chk = 1'b0;
`ifdef UART_PARITY_EN
        par_chk  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                os_clr  = fall;
                bit_clr = 1'b1;
            end
            ST_START: if (tick) begin
                if (os_mid) os_clr = 1'b1;
                else        os_inc = 1'b1;
            end
            ST_DATA: if (tick) begin
                if (os_end) begin
                    os_clr   = 1'b1;
                    shift_en = 1'b1;
                end else begin
                    os_inc   = 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (tick) begin
                if (os_end) begin
                    os_clr  = 1'b1;
                    par_chk = 1'b1;
                end else begin
                    os_inc  = 1'b1;
                end
            end
`endif
            ST_STOP: if (tick) begin
                if (os_end) stop_chk = 1'b1;
                else        os_inc   = 1'b1;
            end
            default: ;
        endcase
    end

    // datapath next state: divider, counters, shifter, push strobe, flags
    always_comb begin
        div_d   = tick ? '0 : div_q + DW'(1);
        os_d    = os_clr ? '0 : (os_inc ? os_q + OW'(1) : os_q);
        bit_d   = bit_clr ? '0 : (shift_en ? bit_q + BW'(1) : bit_q);
        shift_d = shift_en ? {rx_s, shift_q[DATA_BITS-1:1]} : shift_q;
        ferr_d  = (ferr_q & ~err_clr) | (stop_chk & ~rx_s);
        ovf_d   = (ovf_q & ~err_clr) | fifo_drop;
`ifdef UART_PARITY_EN
        push_d    = stop_chk & rx_s & ~par_bad_q;
        par_bad_d = bit_clr ? 1'b0 : (par_bad_q | par_miss);
        perr_d    = (perr_q & ~err_clr) | par_miss;
`else
        push_d    = stop_chk & rx_s;
`endif
    end

    // datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef UART_PARITY_EN
    // parity verdict for the frame in flight and its sticky flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = ferr_q;
    assign overflow  = ovf_q;
    assign push_ok   = push_q;

    // shift_q stays stable long after the stop sample, so it is written directly
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_ok),
        .pop_i   (rd_en),
        .wdata_i (shift_q),
        .rdata_o (rd_data),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count),
        .drop_o  (fifo_drop)
    );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf (CLK_DIV=13, OVERSAMPLE=16, DEPTH=4).
// Optional build macro: UART_PARITY_EN adds parity-bit frames.
module tb_uart_rx_buf;
    localparam int CLK_DIV = 13;
    localparam int OVS     = 16;
    localparam int DB      = 8;
    localparam int DEPTH   = 4;
    localparam int BIT     = CLK_DIV * OVS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DB-1:0] rd_data;
    logic          empty, full;
    logic [2:0]    count;
    logic          overflow, frame_err, parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int fall_cyc = 0;
    logic empty_prev = 1'b1;
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_buf #(
        .CLK_DIV    (CLK_DIV),
        .OVERSAMPLE (OVS),
        .DATA_BITS  (DB),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // cycle stamp of the most recent empty 1->0 transition
    always @(negedge clk) begin
        if (empty_prev && !empty) fall_cyc = cyc;
        empty_prev = empty;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tk(1);
        rd_en = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        tk(1);
        err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        rx = 1'b0;
        tk(BIT);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            tk(BIT);
        end
`ifdef UART_PARITY_EN
        rx = (^d) ^ par_flip;
        tk(BIT);
`endif
        stop_cyc = cyc;
        rx = stop_b;
        tk(BIT);
        rx = 1'b1;
        tk(40);
    endtask

    initial begin
        logic [7:0] bytes [5];
        int delta;
        int n;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55;

        // reset state
        tk(5);
        smp();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        reset = 1'b0;
        tk(20);

        // single good frame
        send_frame(8'hA5, 1'b1);
        smp();
        chk("a5_count", count, 1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_empty", empty, 0);
        delta = fall_cyc - stop_cyc;
        chk("a5_empty_fall_window", (delta >= 90 && delta <= 115), 1);
        pop();
        smp();
        chk("a5_pop_count", count, 0);
        chk("a5_pop_empty", empty, 1);

        // short low glitch is rejected
        rx = 1'b0;
        tk(50);
        rx = 1'b1;
        tk(3 * BIT);
        smp();
        chk("glitch_count", count, 0);
        chk("glitch_ferr", frame_err, 0);
        chk("glitch_ovf", overflow, 0);

        // framing error: stop bit low
        send_frame(8'h5A, 1'b0);
        smp();
        chk("ferr_set", frame_err, 1);
        chk("ferr_count", count, 0);
        clr_err();
        smp();
        chk("ferr_clr", frame_err, 0);

        // overflow: five frames, no reads
        for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1);
        smp();
        chk("ovf_full", full, 1);
        chk("ovf_count", count, 4);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("ovf_rd%0d", i), rd_data, bytes[i]);
            pop();
        end
        smp();
        chk("ovf_drained", empty, 1);
        clr_err();
        smp();
        chk("ovf_clr", overflow, 0);

        // fifth push coincides with a pop: accepted, no overflow
        for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
        smp();
        chk("cc_full_before", full, 1);
        n = 0;
        fork
            send_frame(bytes[4], 1'b1);
            begin
                while (!dut.push_q && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
            end
        join
        chk("cc_push_seen", (n < 5000), 1);
        smp();
        chk("cc_ovf", overflow, 0);
        chk("cc_count", count, 4);
        chk("cc_full", full, 1);
        for (int i = 1; i < 5; i++) begin
            smp();
            chk($sformatf("cc_rd%0d", i), rd_data, bytes[i]);
            pop();
        end
        smp();
        chk("cc_drained", empty, 1);

`ifdef UART_PARITY_EN
        // parity: 0x03 has even ones, so a parity bit of 1 is wrong
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1);
        smp();
        chk("par_err_set", parity_err, 1);
        chk("par_err_count", count, 0);
        clr_err();
        smp();
        chk("par_err_clr", parity_err, 0);
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1);
        smp();
        chk("par_ok_count", count, 1);
        chk("par_ok_data", rd_data, 8'h03);
        pop();
`else
        smp();
        chk("par_tied", parity_err, 0);
`endif

        // reset during bit 4 of a frame, then a clean frame
        send_frame(8'h77, 1'b1);
        smp();
        chk("mid_pre_count", count, 1);
        rx = 1'b0;
        tk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h96 >> i) & 1'b1;
            tk(BIT);
        end
        rx = 1'b1;
        tk(BIT / 2);
        reset = 1'b1;
        tk(10);
        smp();
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);
        reset = 1'b0;
        tk(2 * BIT);
        smp();
        chk("mid_no_push", count, 0);
        send_frame(8'h3C, 1'b1);
        smp();
        chk("mid_count", count, 1);
        chk("mid_data", rd_data, 8'h3C);
        pop();
        smp();
        chk("mid_drained", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
